// File: rtl/constraint_sampler.sv
// Random candidate generator for an external combinational constraint checker.
// A 64-bit LFSR fills a 506-bit candidate register; the checker's verdict picks DONE, retry or FAIL.
module constraint_sampler #(
  parameter int unsigned MAX_TRIES = 1024,
  parameter logic [63:0] SEED      = 64'hACE1_0F0F_5A5A_1234
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        seed_load,
  input  logic [63:0] seed_in,
  output logic [35:0] var_0,
  output logic [50:0] var_1,
  output logic [56:0] var_2,
  output logic [53:0] var_3,
  output logic [59:0] var_4,
  output logic [48:0] var_5,
  output logic [38:0] var_6,
  output logic [56:0] var_7,
  output logic [56:0] var_8,
  output logic [45:0] var_9,
  input  logic        sat,
  output logic        cand_valid,
  output logic        sol_valid,
  input  logic        sol_ready,
  output logic        busy,
  output logic        fail,
  output logic [15:0] tries
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_FAIL  = 3'd4;

  localparam logic [16:0] MAX_TRIES_W = 17'(MAX_TRIES);

  logic [2:0]   state_q, state_d;
  logic [63:0]  lfsr_q, lfsr_d, lfsr_next;
  // The top six candidate bits are never observable, so only bits 505:0 are stored.
  logic [505:0] cand_q, cand_d;
  logic [2:0]   fill_cnt_q, fill_cnt_d;
  logic [15:0]  tries_q, tries_d;
  logic [16:0]  tries_inc;

  assign lfsr_next = {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
  assign tries_inc = {1'b0, tries_q} + 17'd1;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    cand_d     = cand_q;
    fill_cnt_d = fill_cnt_q;
    tries_d    = tries_q;

    case (state_q)
      ST_IDLE: begin
        // A simultaneous seed_load lands before the first FILL step uses the LFSR.
        if (seed_load) lfsr_d = (seed_in == 64'd0) ? SEED : seed_in;
        if (start) begin
          state_d    = ST_FILL;
          tries_d    = 16'd0;
          fill_cnt_d = 3'd0;
        end
      end
      ST_FILL: begin
        lfsr_d     = lfsr_next;
        cand_d     = {cand_q[441:0], lfsr_next};
        fill_cnt_d = fill_cnt_q + 3'd1;
        if (fill_cnt_q == 3'd7) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        tries_d = (tries_q == 16'hFFFF) ? tries_q : tries_inc[15:0];
        if (sat) begin
          state_d = ST_DONE;
        end else if (tries_inc == MAX_TRIES_W) begin
          state_d = ST_FAIL;
        end else begin
          state_d    = ST_FILL;
          fill_cnt_d = 3'd0;
        end
      end
      ST_DONE: begin
        if (sol_ready) state_d = ST_IDLE;
      end
      ST_FAIL: begin
        if (start) begin
          state_d    = ST_FILL;
          tries_d    = 16'd0;
          fill_cnt_d = 3'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= SEED;
      // NOTE: the candidate register is reset on purpose: after reset all var_* must read zero.
      cand_q     <= '0;
      fill_cnt_q <= 3'd0;
      tries_q    <= 16'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cand_q     <= cand_d;
      fill_cnt_q <= fill_cnt_d;
      tries_q    <= tries_d;
    end
  end

  assign var_0 = cand_q[35:0];
  assign var_1 = cand_q[86:36];
  assign var_2 = cand_q[143:87];
  assign var_3 = cand_q[197:144];
  assign var_4 = cand_q[257:198];
  assign var_5 = cand_q[306:258];
  assign var_6 = cand_q[345:307];
  assign var_7 = cand_q[402:346];
  assign var_8 = cand_q[459:403];
  assign var_9 = cand_q[505:460];

  assign cand_valid = (state_q == ST_CHECK) || (state_q == ST_DONE);
  assign sol_valid  = (state_q == ST_DONE);
  assign busy       = (state_q == ST_FILL) || (state_q == ST_CHECK);
  assign fail       = (state_q == ST_FAIL);
  assign tries      = tries_q;

endmodule

// File: tb/tb_constraint_sampler.sv
// Self-checking bench for constraint_sampler: directed sequence with randomized seeds,
// sat patterns and ignored-input noise, checked against a run-level reference model.
module tb_constraint_sampler;

  localparam int          MT     = 4;
  localparam logic [63:0] SEED_P = 64'hACE1_0F0F_5A5A_1234;

  logic        clk = 1'b0;
  logic        rst_n, start, seed_load, sat, sol_ready;
  logic [63:0] seed_in;
  logic [35:0] var_0;
  logic [50:0] var_1;
  logic [56:0] var_2;
  logic [53:0] var_3;
  logic [59:0] var_4;
  logic [48:0] var_5;
  logic [38:0] var_6;
  logic [56:0] var_7;
  logic [56:0] var_8;
  logic [45:0] var_9;
  logic        cand_valid, sol_valid, busy, fail;
  logic [15:0] tries;

  int checks   = 0;
  int failures = 0;

  // Reference model: LFSR word stream, candidate bit vector, tries and FAIL-state flag.
  logic [63:0]  m_lfsr;
  logic [511:0] m_cand;
  int           m_tries;
  bit           m_in_fail;

  bit   use_checker;
  logic sat_force;

  constraint_sampler #(.MAX_TRIES(MT), .SEED(SEED_P)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed_load(seed_load), .seed_in(seed_in),
    .var_0(var_0), .var_1(var_1), .var_2(var_2), .var_3(var_3), .var_4(var_4),
    .var_5(var_5), .var_6(var_6), .var_7(var_7), .var_8(var_8), .var_9(var_9),
    .sat(sat), .cand_valid(cand_valid), .sol_valid(sol_valid), .sol_ready(sol_ready),
    .busy(busy), .fail(fail), .tries(tries)
  );

  always #5 clk = ~clk;

  // Stand-in for the lab checker: holds for roughly half of all candidates.
  function automatic logic lab_check(input logic [35:0] a, input logic [53:0] b);
    return (a[0] ^ b[5]) == 1'b0;
  endfunction

  always_comb sat = use_checker ? lab_check(var_0, var_3) : sat_force;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  function automatic logic [505:0] dut_vec();
    return {var_9, var_8, var_7, var_6, var_5, var_4, var_3, var_2, var_1, var_0};
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Status bits packed as {busy, cand_valid, sol_valid, fail}.
  task automatic check_st(input string tag, input logic [3:0] exp);
    check(tag, 512'({busy, cand_valid, sol_valid, fail}), 512'(exp));
  endtask

  task automatic check_vars(input string tag);
    check(tag, 512'(dut_vec()), 512'(m_cand[505:0]));
  endtask

  task automatic check_tries(input string tag);
    check(tag, 512'(tries), 512'(m_tries));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_lfsr    = SEED_P;
    m_cand    = '0;
    m_tries   = 0;
    m_in_fail = 0;
  endtask

  task automatic model_fill();
    for (int w = 0; w < 8; w++) begin
      m_lfsr = lfsr_step(m_lfsr);
      m_cand = {m_cand[447:0], m_lfsr};
    end
  endtask

  // One sampling run. mode: 0 sat low, 1 sat high, 2 random sat per try, 3 lab checker.
  task automatic run(input int mode, input bit with_seed, input logic [63:0] seed,
                     output bit solved);
    logic exp_sat;
    use_checker = (mode == 3);
    sat_force   = 1'b0;
    start       = 1'b1;
    seed_load   = with_seed;
    seed_in     = seed;
    step();
    start     = 1'b0;
    seed_load = 1'b0;
    if (with_seed && !m_in_fail) m_lfsr = (seed == 64'd0) ? SEED_P : seed;
    m_tries   = 0;
    m_in_fail = 0;
    solved    = 0;
    check_tries("tries_after_start");
    for (int t = 0; t < MT; t++) begin
      for (int c = 0; c < 8; c++) begin
        check_st("fill_status", 4'b1000);
        start     = 1'($urandom_range(0, 1));
        seed_load = 1'($urandom_range(0, 1));
        seed_in   = {$urandom(), $urandom()};
        step();
      end
      start     = 1'b0;
      seed_load = 1'b0;
      model_fill();
      case (mode)
        0:       exp_sat = 1'b0;
        1:       exp_sat = 1'b1;
        2:       exp_sat = 1'($urandom_range(0, 2) == 0);
        default: exp_sat = lab_check(m_cand[35:0], m_cand[197:144]);
      endcase
      if (mode != 3) sat_force = exp_sat;
      check_st("check_status", 4'b1100);
      check_vars("check_vars");
      step();
      m_tries++;
      check_tries("tries_after_check");
      if (exp_sat) begin
        check_st("done_status", 4'b0110);
        check_vars("done_vars");
        if (mode == 3) check("lab_recheck", 512'(lab_check(var_0, var_3)), 512'(1));
        solved = 1;
        break;
      end else if (m_tries == MT) begin
        check_st("fail_status", 4'b0001);
        m_in_fail = 1;
        break;
      end
    end
    sat_force = 1'b0;
  endtask

  // Hold DONE with sol_ready low for five cycles (one ignored start), then accept.
  task automatic done_hold();
    logic [505:0] held;
    held = dut_vec();
    for (int i = 0; i < 5; i++) begin
      sol_ready = 1'b0;
      start     = (i == 2);
      step();
      check_st("done_hold_status", 4'b0110);
      check("done_hold_vars", 512'(dut_vec()), 512'(held));
    end
    start     = 1'b0;
    sol_ready = 1'b1;
    step();
    sol_ready = 1'b0;
    check_st("accept_status", 4'b0000);
    check("idle_retains_vars", 512'(dut_vec()), 512'(held));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_st("reset_status", 4'b0000);
    check_vars("reset_vars");
    check_tries("reset_tries");
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    logic [505:0] from_reset_vars, seed1_vars;
    bit           solved;
    rst_n       = 1'b1;
    start       = 1'b0;
    seed_load   = 1'b0;
    seed_in     = '0;
    sol_ready   = 1'b0;
    use_checker = 0;
    sat_force   = 1'b0;
    #2;
    do_reset();

    // Single-try success straight out of reset.
    run(1, 0, 64'd0, solved);
    if (solved) done_hold();
    from_reset_vars = dut_vec();

    // Seed 1 loaded alone, then reloaded together with start: same candidate.
    seed_load = 1'b1;
    seed_in   = 64'h1;
    step();
    seed_load = 1'b0;
    m_lfsr    = 64'h1;
    run(1, 0, 64'd0, solved);
    if (solved) done_hold();
    seed1_vars = dut_vec();
    run(1, 1, 64'h1, solved);
    if (solved) done_hold();
    check("seed1_repeat", 512'(dut_vec()), 512'(seed1_vars));

    // Zero seed falls back to SEED: same candidate as the first run after reset.
    run(1, 1, 64'd0, solved);
    if (solved) done_hold();
    check("seed0_matches_reset_run", 512'(dut_vec()), 512'(from_reset_vars));

    // Exhaust MAX_TRIES; fail is sticky and seed_load is ignored while failed.
    run(0, 0, 64'd0, solved);
    for (int i = 0; i < 3; i++) begin
      seed_load = 1'b1;
      seed_in   = {$urandom(), $urandom()};
      step();
      check_st("fail_sticky", 4'b0001);
      check_tries("fail_tries");
    end
    seed_load = 1'b0;
    run(2, 1, 64'hDEAD_BEEF_0000_0001, solved);
    if (solved) done_hold();

    // Reset mid-FILL (counter 3) clears outputs without a clock edge.
    if (m_in_fail) begin
      run(1, 0, 64'd0, solved);
      if (solved) done_hold();
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_st("mid_fill_busy", 4'b1000);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_st("async_reset_status", 4'b0000);
    check_vars("async_reset_vars");
    check_tries("async_reset_tries");
    step();
    check_st("reset_held_status", 4'b0000);
    rst_n = 1'b1;
    step();
    check_st("post_reset_idle", 4'b0000);
    run(1, 0, 64'd0, solved);
    if (solved) done_hold();
    check("post_reset_matches_reset_run", 512'(dut_vec()), 512'(from_reset_vars));

    // Randomized runs against the lab checker and random sat patterns.
    for (int r = 0; r < 8; r++) begin
      run((r % 2 == 0) ? 3 : 2, 1'($urandom_range(0, 1)), {$urandom(), $urandom()}, solved);
      if (solved) done_hold();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/constraint_sampler.md
CONSTRAINT_SAMPLER -- requirements
Module: constraint_sampler

Interface
REQ-001 Parameter MAX_TRIES, default 1024, meaning candidates attempted before FAIL (1..65535).
REQ-002 Parameter SEED, default 64'hACE1_0F0F_5A5A_1234, meaning LFSR reset/fallback seed (nonzero).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  begin a sampling run; honored in IDLE or FAIL only.
REQ-006 seed_load  input  1  load seed_in into LFSR; honored in IDLE only.
REQ-007 seed_in  input  64  seed value.
REQ-008 var_0..var_9  output  36,51,57,54,60,49,39,57,57,46  candidate fields driven to the external combinational checker.
REQ-009 sat  input  1  checker result for current var_0..var_9 (1 = all constraints hold).
REQ-010 cand_valid  output  1  var_* stable and sat meaningful (CHECK or DONE).
REQ-011 sol_valid  output  1  var_* hold a satisfying solution.
REQ-012 sol_ready  input  1  consumer accepts solution.
REQ-013 busy  output  1  state is FILL or CHECK.
REQ-014 fail  output  1  MAX_TRIES exhausted without a solution; sticky.
REQ-015 tries  output  16  candidates checked in current/last run.

Function
REQ-016 LFSR: 64-bit Fibonacci, fb = s[63]^s[62]^s[60]^s[59], next = {s[62:0], fb}; advances only in FILL.
REQ-017 Candidate register cand[511:0]: each FILL cycle cand <= {cand[447:0], lfsr_next}.
REQ-018 Field map: var_0=cand[35:0], var_1=[86:36], var_2=[143:87], var_3=[197:144], var_4=[257:198], var_5=[306:258], var_6=[345:307], var_7=[402:346], var_8=[459:403], var_9=[505:460]; cand[511:506] unused.
REQ-019 States IDLE, FILL, CHECK, DONE, FAIL.
REQ-020 IDLE: start -> FILL, tries<=0, fill counter<=0; seed_load and start together: seed applied first, then FILL uses the new seed.
REQ-021 seed_load with seed_in==0 loads SEED instead.
REQ-022 FILL: exactly 8 cycles (counter 0..7), then CHECK.
REQ-023 CHECK: one cycle, cand frozen; tries<=tries+1; sat=1 -> DONE; else tries+1==MAX_TRIES -> FAIL; else FILL with counter 0.
REQ-024 DONE: sol_valid=1, cand frozen; sol_valid && sol_ready -> IDLE at that edge; var_* retain value in IDLE.
REQ-025 FAIL: fail=1 until next accepted start; start -> FILL, fail<=0, tries<=0.
REQ-026 start in FILL, CHECK, DONE ignored; seed_load outside IDLE ignored.
REQ-027 Latency: start sampled at edge k -> sat sampled at edge k+9 -> sol_valid high after edge k+9; each retry costs 9 cycles.
REQ-028 tries saturates at 16'hFFFF (never wraps).
REQ-029 LFSR not reset between runs; consecutive runs continue the sequence.

Reset
REQ-030 rst_n low asynchronously forces: state IDLE, lfsr=SEED, cand=0 (all var_*=0), tries=0, sol_valid=0, cand_valid=0, busy=0, fail=0.
REQ-031 Reset during any state aborts the run; no partial solution survives; after release, start required.

Verification
REQ-032 sat tied 1, start at edge 0 -> busy cycles 1..9, cand_valid in CHECK, sol_valid after edge 9, tries=1.
REQ-033 sat tied 0, MAX_TRIES=4 -> fail high after edge 36 from start, tries=4, sol_valid never 1; second start clears fail, tries=0.
REQ-034 DONE with sol_ready low 5 cycles -> sol_valid and all var_* bit-stable; sol_ready high one cycle -> IDLE, sol_valid=0.
REQ-035 seed_load seed_in=64'h1 then run twice with reload -> identical var_* each run; seed_in=0 -> same var_* as a run from reset.
REQ-036 rst_n low mid-FILL (counter 3) -> var_*=0, busy=0 immediately without clock; sat/start afterwards behave as from reset.
REQ-037 Connected to the lab constraint checker module, sat=its x -> on sol_valid, checker re-evaluated on var_* returns 1; otherwise fail with tries=MAX_TRIES.
